conv_scan_sequencer: RTL and testbench
======================================

Name: conv_scan_sequencer

Overview:
Single-clock sequencer upstream of the wrap shifter. It generates the one-hot kernel-mux, pixel-mux, word-line and memory-pointer selects for one convolution frame, under a start/done handshake with stall support. Its kernel select drives the shifter's shift control, and its word-line select drives the shifter's input state.

Parameters:
NUM_KERN, 3, kernel-mux positions; width of Count3_s1.
NUM_PIX, 8, pixel-mux positions; width of Count8_s1.
NUM_ROWS, 9, word-line positions; width of Count9_s1.
NUM_MEM, 3, frame-buffer pointer positions; width of MemPoint_s1.

Ports:
Phi1  in  1  sole clock; all state updates on its rising edge.
Reset_b_s1  in  1  reset, synchronous, active-low.
Start_s1  in  1  frame request; sampled only in IDLE.
Stall_s1  in  1  hold all counters for this cycle while in RUN.
Busy_s1  out  1  high in RUN and DONE.
Valid_s1  out  1  high in RUN only; selects meaningful.
Done_s1  out  1  one-cycle pulse, DONE state.
Count3_s1  out  NUM_KERN  one-hot kernel select (shift control).
Count8_s1  out  NUM_PIX  one-hot pixel-mux select.
Count9_s1  out  NUM_ROWS  one-hot word-line select.
MemPoint_s1  out  NUM_MEM  one-hot frame-buffer pointer.

Behaviour:
- Reset (Reset_b_s1=0 at edge) values:
  - state IDLE; Busy/Valid/Done 0.
  - Count3=001, Count8=0000_0001, Count9=1_0000_0000, MemPoint=001.
  - Reset has priority over every other input, including mid-frame. No Done is produced for an aborted frame.
- States:
  - IDLE: Start=1 -> RUN next cycle; otherwise stay.
  - RUN: advance when Stall=0. On the advance at the final position -> DONE.
  - DONE: exactly one cycle, then -> IDLE unconditionally. Start is ignored in RUN and DONE; it is not queued.
- Advance (RUN, Stall=0), as a nested odometer:
  - Kernel rotates left (001->010->100->001) every advance.
  - Pixel rotates left (bit7 -> bit0) only when kernel is at 100.
  - Row rotates right (bit0 -> bit8) only when kernel=100 and pixel bit7=1.
- Final position: kernel=100, pixel=1000_0000, row=0_0000_0001.
  - Advancing from it returns all three selects to their reset values.
  - MemPoint rotates left once on the same edge; state -> DONE.
- Frame length is NUM_KERN*NUM_PIX*NUM_ROWS = 216 advancing cycles.
  - With no stalls: Start sampled at edge 0; Valid=1 in cycles 1..216 showing steps 0..215; Done=1 in cycle 217; Busy=0 from cycle 218.
- Stall:
  - A stall on any RUN cycle, including the first or last step, freezes all selects and the state. Valid stays 1.
  - Stall is ignored outside RUN.
- Start with Stall=1 still enters RUN; the bench sees step 0 held.
- In IDLE/DONE the selects hold the reset/initial values. They are never all-zero and never multi-hot.
- MemPoint persists across frames (001->010->100->001) and changes only at frame completion or reset.

Decomposition:
- Shared package holds:
  - state enum (IDLE, RUN, DONE);
  - one-hot initial constants: KERN_INIT=001, PIX_INIT=0000_0001, ROW_INIT=1_0000_0000, MEM_INIT=001.
- Sub-module onehot_ring(WIDTH, INIT, DIR) is a one-hot rotator with synchronous load-init and enable; it is instantiated four times.
- The FSM and the wrap-enable chain stay in the top module.

Test Plan:
- Reset: hold Reset_b_s1=0 two cycles with Start=1 -> IDLE, Busy=0, Count3=001, Count8=01h, Count9=100h, MemPoint=001.
- Full frame, no stall: pulse Start -> exactly 216 Valid cycles, then a one-cycle Done. Step 3 shows Count3=001, Count8=02h. Step 24 shows Count9=080h. Step 215 shows Count3=100, Count8=80h, Count9=001h. After Done, MemPoint=010.
- Stall: assert Stall for 5 cycles at step 100 and at step 215 -> selects frozen throughout; total Valid cycles=226; Done delayed by 10 cycles.
- Start while busy: pulse Start at steps 50 and 215 and during DONE -> no extra frame; returns to IDLE; one Done only.
- Reset mid-frame at step 120 -> next cycle all reset values, no Done, MemPoint=001. A subsequent Start runs a full 216-step frame.
- Three back-to-back frames (Start held high) -> MemPoint 001->010->100->001. IDLE lasts one cycle between frames. One-hot assertion on all selects holds every cycle.

Source files
------------

// File: rtl/conv_scan_sequencer_pkg.sv
// conv_scan_sequencer_pkg
// Types and constants shared by the convolution scan sequencer:
//   - state_e : frame FSM states (IDLE, RUN, DONE)
//   - dir_e   : rotation direction of a one-hot ring
//   - *_INIT  : one-hot reset/initial values of the four selects
package conv_scan_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam logic [2:0] KERN_INIT = 3'b001;
  localparam logic [7:0] PIX_INIT  = 8'b0000_0001;
  localparam logic [8:0] ROW_INIT  = 9'b1_0000_0000;
  localparam logic [2:0] MEM_INIT  = 3'b001;

endpackage

// File: rtl/conv_scan_sequencer_if.sv
// conv_scan_sequencer_if
// Start/stall handshake and one-hot select bus of the scan sequencer.
//   master : frame requester; drives Start_s1/Stall_s1, observes the rest
//   slave  : the sequencer; drives Busy/Valid/Done and the four selects
interface conv_scan_sequencer_if #(
  parameter int NUM_KERN = 3,
  parameter int NUM_PIX  = 8,
  parameter int NUM_ROWS = 9,
  parameter int NUM_MEM  = 3
);
  logic                Start_s1;
  logic                Stall_s1;
  logic                Busy_s1;
  logic                Valid_s1;
  logic                Done_s1;
  logic [NUM_KERN-1:0] Count3_s1;
  logic [NUM_PIX-1:0]  Count8_s1;
  logic [NUM_ROWS-1:0] Count9_s1;
  logic [NUM_MEM-1:0]  MemPoint_s1;

  modport master (
    output Start_s1, Stall_s1,
    input  Busy_s1, Valid_s1, Done_s1,
    input  Count3_s1, Count8_s1, Count9_s1, MemPoint_s1
  );

  modport slave (
    input  Start_s1, Stall_s1,
    output Busy_s1, Valid_s1, Done_s1,
    output Count3_s1, Count8_s1, Count9_s1, MemPoint_s1
  );
endinterface

// File: rtl/conv_scan_sequencer_onehot_ring.sv
// onehot_ring
// One-hot rotating register. Synchronous active-low reset and synchronous
// load both restore INIT; otherwise the register rotates one position per
// enabled cycle in direction DIR.
//   clk_i   : clock
//   rst_n_i : synchronous reset, active-low
//   load_i  : synchronous load of INIT (lower priority than reset only)
//   en_i    : rotate enable
//   q_o     : one-hot state
module onehot_ring
  import conv_scan_sequencer_pkg::*;
#(
  parameter int               WIDTH = 3,
  parameter logic [WIDTH-1:0] INIT  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter dir_e             DIR   = DIR_LEFT
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (DIR == DIR_LEFT) q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
    else                 q_d = {q_q[0], q_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || load_i) q_q <= INIT;
    else if (en_i)          q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/conv_scan_sequencer.sv
// conv_scan_sequencer
// Generates the one-hot kernel, pixel, word-line and frame-buffer pointer
// selects for one convolution frame. Kernel, pixel and row form a nested
// odometer (kernel fastest, row slowest); the pointer advances once per
// completed frame and persists across frames.
//   Phi1        : clock
//   Reset_b_s1  : synchronous reset, active-low
//   bus (slave) : Start/Stall in; Busy/Valid/Done and the selects out
module conv_scan_sequencer
  import conv_scan_sequencer_pkg::*;
#(
  parameter int NUM_KERN = 3,
  parameter int NUM_PIX  = 8,
  parameter int NUM_ROWS = 9,
  parameter int NUM_MEM  = 3
) (
  input  logic                  Phi1,
  input  logic                  Reset_b_s1,
  conv_scan_sequencer_if.slave  bus
);

  state_e state_q;
  logic   busy_q, valid_q, done_q;

  logic [NUM_KERN-1:0] kern;
  logic [NUM_PIX-1:0]  pix;
  logic [NUM_ROWS-1:0] row;
  logic [NUM_MEM-1:0]  mem;

  logic adv, kern_en, pix_en, row_en, frame_end, sel_load;

  // Wrap-enable chain: each ring steps only when every faster ring wraps.
  assign adv       = (state_q == RUN) && !bus.Stall_s1;
  assign kern_en   = adv;
  assign pix_en    = kern_en && kern[NUM_KERN-1];
  assign row_en    = pix_en && pix[NUM_PIX-1];
  assign frame_end = row_en && row[0];

  // Outside a frame the odometer is pinned to its start position.
  assign sel_load  = (state_q == IDLE);

  onehot_ring #(.WIDTH(NUM_KERN), .INIT(KERN_INIT), .DIR(DIR_LEFT)) u_kern (
    .clk_i(Phi1), .rst_n_i(Reset_b_s1), .load_i(sel_load), .en_i(kern_en), .q_o(kern)
  );

  onehot_ring #(.WIDTH(NUM_PIX), .INIT(PIX_INIT), .DIR(DIR_LEFT)) u_pix (
    .clk_i(Phi1), .rst_n_i(Reset_b_s1), .load_i(sel_load), .en_i(pix_en), .q_o(pix)
  );

  onehot_ring #(.WIDTH(NUM_ROWS), .INIT(ROW_INIT), .DIR(DIR_RIGHT)) u_row (
    .clk_i(Phi1), .rst_n_i(Reset_b_s1), .load_i(sel_load), .en_i(row_en), .q_o(row)
  );

  // The frame pointer is never reloaded outside reset so it survives frames.
  onehot_ring #(.WIDTH(NUM_MEM), .INIT(MEM_INIT), .DIR(DIR_LEFT)) u_mem (
    .clk_i(Phi1), .rst_n_i(Reset_b_s1), .load_i(1'b0), .en_i(frame_end), .q_o(mem)
  );

  // Frame FSM with registered status outputs.
  always_ff @(posedge Phi1) begin
    if (!Reset_b_s1) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.Start_s1) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
          end
        end
        RUN: begin
          if (frame_end) begin
            state_q <= DONE;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy_s1     = busy_q;
  assign bus.Valid_s1    = valid_q;
  assign bus.Done_s1     = done_q;
  assign bus.Count3_s1   = kern;
  assign bus.Count8_s1   = pix;
  assign bus.Count9_s1   = row;
  assign bus.MemPoint_s1 = mem;

endmodule

// File: tb/tb_conv_scan_sequencer.sv
// Testbench for conv_scan_sequencer: directed frame scenarios, a table of
// select values at chosen steps, and a randomized phase, all checked
// cycle-by-cycle against a step-counter reference model.
module tb_conv_scan_sequencer;

  localparam int FRAME = 216;

  logic Phi1 = 1'b0;
  logic Reset_b_s1;

  always #5 Phi1 = ~Phi1;

  conv_scan_sequencer_if bus ();

  conv_scan_sequencer dut (
    .Phi1      (Phi1),
    .Reset_b_s1(Reset_b_s1),
    .bus       (bus)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: mode 0=idle 1=run 2=done; step = frame position 0..215
  int m_mode, m_step, m_frames;
  int valid_cnt, done_cnt, idle_cnt;

  typedef struct {
    int         step;
    logic [2:0] c3;
    logic [7:0] c8;
    logic [8:0] c9;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    else passed++;
  endtask

  function automatic logic [25:0] model_vec();
    logic [2:0] c3;
    logic [7:0] c8;
    logic [8:0] c9;
    logic [2:0] mem;
    c3  = 3'(1 << (m_step % 3));
    c8  = 8'(1 << ((m_step / 3) % 8));
    c9  = 9'(1 << (8 - (m_step / 24) % 9));
    mem = 3'(1 << (m_frames % 3));
    return {m_mode != 0, m_mode == 1, m_mode == 2, c3, c8, c9, mem};
  endfunction

  task automatic model_update();
    if (!Reset_b_s1) begin
      m_mode = 0; m_step = 0; m_frames = 0;
    end else begin
      case (m_mode)
        0: if (bus.Start_s1) begin m_mode = 1; m_step = 0; end
        1: if (!bus.Stall_s1) begin
             if (m_step == FRAME - 1) begin m_mode = 2; m_step = 0; m_frames++; end
             else m_step++;
           end
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic tick();
    logic [25:0] act;
    @(posedge Phi1);
    model_update();
    #1;
    valid_cnt += int'(bus.Valid_s1);
    done_cnt  += int'(bus.Done_s1);
    idle_cnt  += int'(!bus.Busy_s1);
    act = {bus.Busy_s1, bus.Valid_s1, bus.Done_s1, bus.Count3_s1, bus.Count8_s1,
           bus.Count9_s1, bus.MemPoint_s1};
    check("cycle_outputs", {6'b0, act}, {6'b0, model_vec()});
    check("onehot", {31'b0, $onehot(bus.Count3_s1) && $onehot(bus.Count8_s1) &&
                             $onehot(bus.Count9_s1) && $onehot(bus.MemPoint_s1)}, 32'd1);
  endtask

  task automatic clr_counts();
    valid_cnt = 0; done_cnt = 0; idle_cnt = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, {31'b0, bus.Busy_s1}, 32'd0);
    check({tag, "_c3"},   {29'b0, bus.Count3_s1}, 32'h1);
    check({tag, "_c8"},   {24'b0, bus.Count8_s1}, 32'h01);
    check({tag, "_c9"},   {23'b0, bus.Count9_s1}, 32'h100);
    check({tag, "_mem"},  {29'b0, bus.MemPoint_s1}, 32'h1);
  endtask

  // Full frame with a single Start pulse, table compares at chosen steps
  task automatic full_frame(input logic [2:0] mem_after);
    clr_counts();
    bus.Start_s1 = 1'b1;
    for (int k = 0; k < FRAME; k++) begin
      tick();
      bus.Start_s1 = 1'b0;
      foreach (vecs[i])
        if (vecs[i].step == k)
          check($sformatf("vec_step%0d", k),
                {12'b0, bus.Count3_s1, bus.Count8_s1, bus.Count9_s1},
                {12'b0, vecs[i].c3, vecs[i].c8, vecs[i].c9});
    end
    tick();
    check("done_pulse", {31'b0, bus.Done_s1}, 32'd1);
    tick();
    check("idle_after_done", {31'b0, bus.Busy_s1}, 32'd0);
    check("frame_valid_cnt", valid_cnt, FRAME);
    check("frame_done_cnt", done_cnt, 1);
    check("mem_after_frame", {29'b0, bus.MemPoint_s1}, {29'b0, mem_after});
  endtask

  initial begin
    int s100, s215, done_at, n;
    logic [2:0] mem_seq[3];

    vecs[0] = '{0,   3'b001, 8'h01, 9'h100};
    vecs[1] = '{3,   3'b001, 8'h02, 9'h100};
    vecs[2] = '{23,  3'b100, 8'h80, 9'h100};
    vecs[3] = '{24,  3'b001, 8'h01, 9'h080};
    vecs[4] = '{100, 3'b010, 8'h02, 9'h010};
    vecs[5] = '{120, 3'b001, 8'h01, 9'h008};
    vecs[6] = '{215, 3'b100, 8'h80, 9'h001};

    m_mode = 0; m_step = 0; m_frames = 0;
    clr_counts();
    Reset_b_s1   = 1'b0;
    bus.Start_s1 = 1'b1;
    bus.Stall_s1 = 1'b0;

    // Reset held two cycles with Start high
    tick(); tick();
    check_reset_vals("reset");
    check("reset_valid", {31'b0, bus.Valid_s1}, 32'd0);
    check("reset_done", {31'b0, bus.Done_s1}, 32'd0);
    Reset_b_s1   = 1'b1;

    // Plain frame
    full_frame(3'b010);

    // Stalls of 5 cycles at steps 100 and 215
    clr_counts();
    s100 = 0; s215 = 0; done_at = 0;
    bus.Start_s1 = 1'b1;
    tick();
    bus.Start_s1 = 1'b0;
    n = 1;
    while (done_cnt == 0 && n < 400) begin
      bus.Stall_s1 = 1'b0;
      if (m_mode == 1 && m_step == 100 && s100 < 5) begin bus.Stall_s1 = 1'b1; s100++; end
      if (m_mode == 1 && m_step == 215 && s215 < 5) begin bus.Stall_s1 = 1'b1; s215++; end
      tick();
      n++;
      if (done_cnt == 1) done_at = n;
    end
    bus.Stall_s1 = 1'b0;
    check("stall_valid_cnt", valid_cnt, FRAME + 10);
    check("stall_done_cycle", done_at, FRAME + 1 + 10);
    tick();
    check("stall_mem", {29'b0, bus.MemPoint_s1}, 32'h4);

    // Reset mid-frame at step 120
    clr_counts();
    bus.Start_s1 = 1'b1;
    tick();
    bus.Start_s1 = 1'b0;
    for (int k = 0; k < 300 && !(m_mode == 1 && m_step == 120); k++) tick();
    check("reached_step120", {29'b0, bus.Count9_s1 == 9'h008, bus.Count3_s1 == 3'b001,
                              bus.Valid_s1}, 32'h7);
    Reset_b_s1 = 1'b0;
    tick();
    Reset_b_s1 = 1'b1;
    check_reset_vals("midreset");
    tick(); tick(); tick();
    check("midreset_no_done", done_cnt, 0);
    full_frame(3'b010);

    // Start pulses while busy: mid-frame, last step and during DONE
    clr_counts();
    bus.Start_s1 = 1'b1;
    tick();
    for (int k = 0; k < 300; k++) begin
      bus.Start_s1 = (m_mode == 1 && (m_step == 50 || m_step == 215)) || (m_mode == 2);
      tick();
      if (done_cnt != 0 && m_mode == 0) break;
    end
    bus.Start_s1 = 1'b0;
    repeat (5) tick();
    check("busy_start_done_cnt", done_cnt, 1);
    check("busy_start_valid_cnt", valid_cnt, FRAME);
    check("busy_start_idle", {31'b0, bus.Busy_s1}, 32'd0);

    // Three back-to-back frames with Start held high, from a fresh reset
    Reset_b_s1 = 1'b0;
    tick();
    Reset_b_s1 = 1'b1;
    clr_counts();
    bus.Start_s1 = 1'b1;
    for (int k = 0; k < 1000 && done_cnt < 3; k++) begin
      tick();
      if (bus.Done_s1) mem_seq[done_cnt-1] = bus.MemPoint_s1;
    end
    bus.Start_s1 = 1'b0;
    check("b2b_done_cnt", done_cnt, 3);
    check("b2b_valid_cnt", valid_cnt, 3 * FRAME);
    check("b2b_idle_gaps", idle_cnt, 2);
    check("b2b_mem1", {29'b0, mem_seq[0]}, 32'h2);
    check("b2b_mem2", {29'b0, mem_seq[1]}, 32'h4);
    check("b2b_mem3", {29'b0, mem_seq[2]}, 32'h1);
    tick();

    // Randomized start/stall/reset traffic
    for (int k = 0; k < 3000; k++) begin
      Reset_b_s1   = ($urandom_range(0, 299) != 0);
      bus.Start_s1 = ($urandom_range(0, 3) == 0);
      bus.Stall_s1 = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
